// File: rtl/spc7110_rom_arbiter.sv
// SPC7110 ROM read-port arbiter: SNES banked fetch, data-port prefetch and decompressor fetch
// share one memory-controller port. Optional grant/timeout statistics: define SPC7110_ARB_STATS_EN.
module spc7110_rom_arbiter #(
   parameter logic [23:0] DROM_BASE = 24'h100000,
   parameter int          TIMEOUT   = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [2:0]  block_dn_select,
   input  logic [2:0]  block_en_select,
   input  logic [2:0]  block_fn_select,
   input  logic        snes_req,
   input  logic [23:0] snes_addr,
   output logic        snes_ack,
   output logic [7:0]  snes_data,
   input  logic        dp_req,
   input  logic [22:0] dp_addr,
   output logic        dp_ack,
   input  logic        dc_req,
   input  logic [22:0] dc_addr,
   output logic        dc_ack,
   output logic [7:0]  rd_data,
   output logic        rd_err,
   output logic        rom_req,
   output logic [23:0] rom_addr,
   input  logic        rom_ack,
   input  logic [7:0]  rom_data
`ifdef SPC7110_ARB_STATS_EN
   ,
   output logic [15:0] stat_snes,
   output logic [15:0] stat_dp,
   output logic [15:0] stat_dc,
   output logic [7:0]  stat_timeout
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef enum logic [1:0] {G_SNES, G_DP, G_DC} grant_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q;
   grant_t      grant_q;
   grant_t      grant_d;
   logic        grant_vld_d;
   logic [23:0] addr_d;
   logic        rr_last_q;
   logic [7:0]  cnt_q;
   logic        rom_req_q;
   logic [23:0] rom_addr_q;
   logic        snes_ack_q;
   logic        dp_ack_q;
   logic        dc_ack_q;
   logic [7:0]  snes_data_q;
   logic [7:0]  rd_data_q;
   logic        rd_err_q;

   // Banks $D0-$FF go through the block-select latches; everything else maps to the program ROM.
   function automatic logic [23:0] map_snes(input logic [23:0] a, input logic [2:0] dn,
                                            input logic [2:0] en, input logic [2:0] fn);
      logic [2:0] sel;
      sel = (a[23:20] == 4'hD) ? dn : (a[23:20] == 4'hE) ? en : fn;
      if (a[23:20] >= 4'hD)
         map_snes = DROM_BASE + {1'b0, sel, 20'h0} + {4'h0, a[19:0]};
      else
         map_snes = {4'h0, a[19:0]};
   endfunction

   function automatic logic [23:0] map_drom(input logic [22:0] a);
      map_drom = DROM_BASE + {1'b0, a};
   endfunction

   always_comb begin
      grant_vld_d = 1'b1;
      grant_d     = G_SNES;
      addr_d      = map_snes(snes_addr, block_dn_select, block_en_select, block_fn_select);
      if (snes_req) begin
         grant_d = G_SNES;
      end else if (dp_req && (!dc_req || !rr_last_q)) begin
         grant_d = G_DP;
         addr_d  = map_drom(dp_addr);
      end else if (dc_req) begin
         grant_d = G_DC;
         addr_d  = map_drom(dc_addr);
      end else begin
         grant_vld_d = 1'b0;
      end
   end

`ifdef SPC7110_ARB_STATS_EN
   logic [15:0] stat_snes_q, stat_dp_q, stat_dc_q;
   logic [7:0]  stat_timeout_q;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge CLK) begin
      if (RESET) begin
         stat_snes_q    <= '0;
         stat_dp_q      <= '0;
         stat_dc_q      <= '0;
         stat_timeout_q <= '0;
      end else begin
         if (state_q == IDLE && grant_vld_d) begin
            if (grant_d == G_SNES) stat_snes_q <= sat_inc16(stat_snes_q);
            if (grant_d == G_DP)   stat_dp_q   <= sat_inc16(stat_dp_q);
            if (grant_d == G_DC)   stat_dc_q   <= sat_inc16(stat_dc_q);
         end
         if (state_q == WAIT && !rom_ack && cnt_q == TO_LAST)
            stat_timeout_q <= sat_inc8(stat_timeout_q);
      end
   end

   assign stat_snes    = stat_snes_q;
   assign stat_dp      = stat_dp_q;
   assign stat_dc      = stat_dc_q;
   assign stat_timeout = stat_timeout_q;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         grant_q     <= G_SNES;
         rr_last_q   <= 1'b0;
         cnt_q       <= '0;
         rom_req_q   <= 1'b0;
         rom_addr_q  <= '0;
         snes_ack_q  <= 1'b0;
         dp_ack_q    <= 1'b0;
         dc_ack_q    <= 1'b0;
         snes_data_q <= 8'h00;
         rd_data_q   <= 8'h00;
         rd_err_q    <= 1'b0;
      end else begin
         snes_ack_q <= 1'b0;
         dp_ack_q   <= 1'b0;
         dc_ack_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (grant_vld_d) begin
                  grant_q    <= grant_d;
                  rom_addr_q <= addr_d;
                  rom_req_q  <= 1'b1;
                  state_q    <= ISSUE;
                  if (grant_d == G_DP) rr_last_q <= 1'b1;
                  if (grant_d == G_DC) rr_last_q <= 1'b0;
               end
            end
            ISSUE: begin
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               // rom_ack takes precedence over a timeout landing in the same cycle.
               if (rom_ack || cnt_q == TO_LAST) begin
                  rom_req_q <= 1'b0;
                  state_q   <= DONE;
                  rd_err_q  <= !rom_ack && (grant_q != G_SNES);
                  if (grant_q == G_SNES) snes_data_q <= rom_ack ? rom_data : 8'hFF;
                  else                   rd_data_q   <= rom_ack ? rom_data : 8'hFF;
                  snes_ack_q <= (grant_q == G_SNES);
                  dp_ack_q   <= (grant_q == G_DP);
                  dc_ack_q   <= (grant_q == G_DC);
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE: begin
               rd_err_q <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign snes_ack  = snes_ack_q;
   assign dp_ack    = dp_ack_q;
   assign dc_ack    = dc_ack_q;
   assign snes_data = snes_data_q;
   assign rd_data   = rd_data_q;
   assign rd_err    = rd_err_q;
   assign rom_req   = rom_req_q;
   assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_spc7110_rom_arbiter.sv
// Directed scoreboard bench for spc7110_rom_arbiter: mapping, arbitration, timeout, reset and wrap.
module tb_spc7110_rom_arbiter;

   localparam int TIMEOUT = 16;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [2:0]  block_dn_select = '0, block_en_select = '0, block_fn_select = '0;
   logic        snes_req = 1'b0;
   logic [23:0] snes_addr = '0;
   logic        snes_ack;
   logic [7:0]  snes_data;
   logic        dp_req = 1'b0;
   logic [22:0] dp_addr = '0;
   logic        dp_ack;
   logic        dc_req = 1'b0;
   logic [22:0] dc_addr = '0;
   logic        dc_ack;
   logic [7:0]  rd_data;
   logic        rd_err;
   logic        rom_req;
   logic [23:0] rom_addr;
   logic        rom_ack = 1'b0;
   logic [7:0]  rom_data = '0;

   // second instance with a high data-ROM base to exercise 24-bit wrap
   logic        w_dc_req = 1'b0;
   logic [22:0] w_dc_addr = '0;
   logic        w_rom_ack = 1'b0;
   logic [7:0]  w_rom_data = '0;
   logic        w_snes_ack, w_dp_ack, w_dc_ack, w_rd_err, w_rom_req;
   logic [7:0]  w_snes_data, w_rd_data;
   logic [23:0] w_rom_addr;
   logic [2:0]  z3 = '0;
   logic [22:0] z23 = '0;
   logic [23:0] z24 = '0;
   logic        z1 = 1'b0;

`ifdef SPC7110_ARB_STATS_EN
   logic [15:0] st_snes, st_dp, st_dc, w_st_snes, w_st_dp, w_st_dc;
   logic [7:0]  st_to, w_st_to;
`endif

   always #5 CLK = ~CLK;

   spc7110_rom_arbiter #(.DROM_BASE(24'h100000), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RESET(RESET),
      .block_dn_select(block_dn_select), .block_en_select(block_en_select),
      .block_fn_select(block_fn_select),
      .snes_req(snes_req), .snes_addr(snes_addr), .snes_ack(snes_ack), .snes_data(snes_data),
      .dp_req(dp_req), .dp_addr(dp_addr), .dp_ack(dp_ack),
      .dc_req(dc_req), .dc_addr(dc_addr), .dc_ack(dc_ack),
      .rd_data(rd_data), .rd_err(rd_err),
      .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data)
`ifdef SPC7110_ARB_STATS_EN
      , .stat_snes(st_snes), .stat_dp(st_dp), .stat_dc(st_dc), .stat_timeout(st_to)
`endif
   );

   spc7110_rom_arbiter #(.DROM_BASE(24'hF00000), .TIMEOUT(TIMEOUT)) u_wrap (
      .CLK(CLK), .RESET(RESET),
      .block_dn_select(z3), .block_en_select(z3), .block_fn_select(z3),
      .snes_req(z1), .snes_addr(z24), .snes_ack(w_snes_ack), .snes_data(w_snes_data),
      .dp_req(z1), .dp_addr(z23), .dp_ack(w_dp_ack),
      .dc_req(w_dc_req), .dc_addr(w_dc_addr), .dc_ack(w_dc_ack),
      .rd_data(w_rd_data), .rd_err(w_rd_err),
      .rom_req(w_rom_req), .rom_addr(w_rom_addr), .rom_ack(w_rom_ack), .rom_data(w_rom_data)
`ifdef SPC7110_ARB_STATS_EN
      , .stat_snes(w_st_snes), .stat_dp(w_st_dp), .stat_dc(w_st_dc), .stat_timeout(w_st_to)
`endif
   );

   typedef struct {
      int          who;   // 0 snes, 1 dp, 2 dc
      logic [23:0] addr;
      logic [7:0]  data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int who, input logic [23:0] a, input logic [7:0] d, input logic e);
      exp_t x;
      x.who = who; x.addr = a; x.data = d; x.err = e;
      sb.push_back(x);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // wait_cyc >= 0: WAIT cycles before rom_ack is returned; wait_cyc < 0: never answer.
   task automatic txn(input int wait_cyc, input logic [7:0] data, input bit drop, input bit scramble);
      exp_t e;
      int   n;
      int   hi;
      int   who_o;
      e = sb.pop_front();
      n = 0;
      while (!rom_req && n < 40) begin
         tick();
         n++;
      end
      check("rom_req_rise", rom_req, 1);
      check("rom_addr", rom_addr, e.addr);
      if (scramble) begin
         block_dn_select = 3'd1; block_en_select = 3'd2; block_fn_select = 3'd3;
         snes_addr = 24'hDABCDE; dp_addr = 23'h3AAAAA; dc_addr = 23'h255555;
      end
      tick();
      if (scramble) check("addr_hold", rom_addr, e.addr);
      if (wait_cyc >= 0) begin
         repeat (wait_cyc) tick();
         rom_ack = 1'b1;
         rom_data = data;
         tick();
         rom_ack = 1'b0;
         rom_data = 8'($urandom);
      end else begin
         hi = 0;
         while (rom_req && hi < 60) begin
            hi++;
            tick();
         end
         check("timeout_cycles", hi, TIMEOUT);
      end
      who_o = snes_ack ? 0 : dp_ack ? 1 : dc_ack ? 2 : 3;
      check("ack_who", who_o, e.who);
      check("ack_onehot", int'(snes_ack) + int'(dp_ack) + int'(dc_ack), 1);
      check("ack_data", (e.who == 0) ? snes_data : rd_data, e.data);
      check("rd_err", rd_err, e.err);
      check("rom_req_drop", rom_req, 0);
      if (drop) begin
         if (e.who == 0) snes_req = 1'b0;
         if (e.who == 1) dp_req = 1'b0;
         if (e.who == 2) dc_req = 1'b0;
      end
      tick();
      check("ack_pulse", snes_ack | dp_ack | dc_ack, 0);
   endtask

   initial begin
      int n;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;

      check("rst_rom_req", rom_req, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_acks", {snes_ack, dp_ack, dc_ack}, 0);
      check("rst_snes_data", snes_data, 8'h00);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_rd_err", rd_err, 0);

      // E bank through block 5, with address/select changes while in flight
      block_en_select = 3'd5;
      snes_addr = 24'hE12345;
      snes_req = 1'b1;
      push(0, 24'h612345, 8'hA5, 1'b0);
      tick();
      check("grant_latency", rom_req, 1);
      txn(0, 8'hA5, 1'b1, 1'b1);

      snes_addr = 24'hC01234;
      snes_req = 1'b1;
      push(0, 24'h001234, 8'h5A, 1'b0);
      txn(3, 8'h5A, 1'b1, 1'b0);

      // ack on the last permitted WAIT cycle beats the timeout
      block_fn_select = 3'd7;
      snes_addr = 24'hF00000;
      snes_req = 1'b1;
      push(0, 24'h800000, 8'h0F, 1'b0);
      txn(TIMEOUT - 1, 8'h0F, 1'b1, 1'b0);

      dp_addr = 23'h000010;
      dp_req = 1'b1;
      push(1, 24'h100010, 8'h11, 1'b0);
      txn(0, 8'h11, 1'b1, 1'b0);

      dc_addr = 23'h7FFFFF;
      dc_req = 1'b1;
      push(2, 24'h8FFFFF, 8'h22, 1'b0);
      txn(1, 8'h22, 1'b1, 1'b0);

      // round robin with both held, SNES cutting in between
      dp_addr = 23'h001000;
      dc_addr = 23'h002000;
      dp_req = 1'b1;
      dc_req = 1'b1;
      push(1, 24'h101000, 8'h31, 1'b0);
      txn(0, 8'h31, 1'b0, 1'b0);
      push(2, 24'h102000, 8'h32, 1'b0);
      txn(2, 8'h32, 1'b0, 1'b0);
      snes_addr = 24'hC00042;
      snes_req = 1'b1;
      push(0, 24'h000042, 8'h33, 1'b0);
      txn(0, 8'h33, 1'b1, 1'b0);
      push(1, 24'h101000, 8'h34, 1'b0);
      txn(1, 8'h34, 1'b1, 1'b0);
      push(2, 24'h102000, 8'h35, 1'b0);
      txn(0, 8'h35, 1'b1, 1'b0);

      // dp timeout, then a stray late rom_ack
      dp_addr = 23'h000123;
      dp_req = 1'b1;
      push(1, 24'h100123, 8'hFF, 1'b1);
      txn(-1, 8'h00, 1'b1, 1'b0);
      rom_ack = 1'b1;
      rom_data = 8'h77;
      tick();
      rom_ack = 1'b0;
      check("late_ack_req", rom_req, 0);
      check("late_ack_acks", {snes_ack, dp_ack, dc_ack}, 0);
      tick();
      check("late_ack_acks2", {snes_ack, dp_ack, dc_ack}, 0);
      check("late_ack_err", rd_err, 0);

      snes_addr = 24'hC00001;
      snes_req = 1'b1;
      push(0, 24'h000001, 8'hFF, 1'b0);
      txn(-1, 8'h00, 1'b1, 1'b0);

      // reset during WAIT, requester keeps asserting
      dp_addr = 23'h000077;
      dp_req = 1'b1;
      n = 0;
      while (!rom_req && n < 40) begin
         tick();
         n++;
      end
      check("rst_txn_req", rom_req, 1);
      tick();
      tick();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check("rst_mid_req", rom_req, 0);
      check("rst_mid_acks", {snes_ack, dp_ack, dc_ack}, 0);
      tick();
      check("rst_reissue", rom_req, 1);
      push(1, 24'h100077, 8'h77, 1'b0);
      txn(1, 8'h77, 1'b1, 1'b0);

      // 24-bit wrap with DROM_BASE = F00000
      w_dc_addr = 23'h7FFFFF;
      w_dc_req = 1'b1;
      tick();
      check("wrap_req", w_rom_req, 1);
      check("wrap_addr", w_rom_addr, 24'h6FFFFF);
      tick();
      w_rom_ack = 1'b1;
      w_rom_data = 8'h3C;
      tick();
      w_rom_ack = 1'b0;
      w_dc_req = 1'b0;
      check("wrap_ack", w_dc_ack, 1);
      check("wrap_data", w_rd_data, 8'h3C);
      check("wrap_err", w_rd_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
